// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fp_pkg
// Description : Shared widths, bit positions and enumerations for the float
//               adder shift sequencer and its helper blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    // Mantissa layout: [27] carry, [26] hidden, [25:3] fraction, [2:0] G/R/S
    localparam int MW         = 28;
    localparam int EW         = 8;
    localparam int HIDDEN_BIT = 26;
    localparam int CARRY_BIT  = 27;

    // Width of a single-cycle shift amount (covers 0..27)
    localparam int KW         = 5;

    typedef enum logic {
        CMD_ALIGN = 1'b0,
        CMD_NORM  = 1'b1
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_NORM  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_step_shifter.sv
`default_nettype none
// ============================================================================
// Module      : fp_step_shifter
// Description : Narrow logical shifter used for the per-cycle mantissa steps.
//               LEFT=1 selects a left shift, LEFT=0 a right shift. Zeros are
//               shifted in; the caller collects any sticky information.
// Revision    : 1.0 - initial release
// Ports       : data   - value to shift
//               amt    - shift distance
//               result - shifted value
// ============================================================================
module fp_step_shifter #(
    parameter int W    = 28,
    parameter int AW   = 5,
    parameter bit LEFT = 1'b0
) (
    input  logic [W-1:0]  data,
    input  logic [AW-1:0] amt,
    output logic [W-1:0]  result
);

    generate
        if (LEFT) begin : g_left
            assign result = data << amt;
        end else begin : g_right
            assign result = data >> amt;
        end
    endgenerate

endmodule : fp_step_shifter
`default_nettype wire

// File: rtl/lzc28.sv
`default_nettype none
// ============================================================================
// Module      : lzc28
// Description : Combinational leading-zero count of a 27-bit field, counted
//               from bit 26 downwards. Returns 27 when the field is zero.
// Revision    : 1.0 - initial release
// Ports       : mantis - mantissa bits [26:0]
//               count  - number of zeros above the most significant one
// ============================================================================
module lzc28 (
    input  logic [26:0] mantis,
    output logic [4:0]  count
);

    // Scan upwards so the highest set bit is the last one to win.
    always_comb begin
        count = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (mantis[i]) begin
                count = 5'(26 - i);
            end
        end
    end

endmodule : lzc28
`default_nettype wire

// File: rtl/fp_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fp_shift_sequencer
// Description : Multi-cycle controller for the shared mantissa/exponent shift
//               path of the float adder. ALIGN right-shifts a mantissa by an
//               exponent difference with sticky collection; NORMALIZE moves
//               the leading one to the hidden-bit position. At most STEP bit
//               positions are shifted per cycle.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n            - clock, synchronous active-low reset
//               in_valid/in_ready     - command handshake (ready only in IDLE)
//               in_cmd                - 0 = ALIGN, 1 = NORMALIZE
//               in_exp/in_mantis      - operand exponent and mantissa
//               in_shamt              - ALIGN right-shift distance
//               out_valid/out_ready   - result handshake
//               out_exp/out_mantis    - result exponent and mantissa
//               out_ovf               - exponent saturated at 255
//               out_unf               - NORMALIZE stopped at minimum exponent
//               out_zero              - NORMALIZE input mantissa was zero
//               busy                  - sequencer not idle
// ============================================================================
module fp_shift_sequencer
    import fp_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_cmd,
    input  logic [EW-1:0] in_exp,
    input  logic [MW-1:0] in_mantis,
    input  logic [EW-1:0] in_shamt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] out_exp,
    output logic [MW-1:0] out_mantis,
    output logic          out_ovf,
    output logic          out_unf,
    output logic          out_zero,
    output logic          busy
);

    localparam logic [KW-1:0] STEP_K  = KW'(STEP);
    localparam logic [EW-1:0] STEP_E  = EW'(STEP);
    localparam logic [EW-1:0] EXP_MAX = {EW{1'b1}};

    state_e         r_state, w_state_nxt;
    logic [EW-1:0]  r_exp, w_exp_nxt;
    logic [MW-1:0]  r_mantis, w_mantis_nxt;
    logic [EW-1:0]  r_rem, w_rem_nxt;
    logic           r_ovf, w_ovf_nxt;
    logic           r_unf, w_unf_nxt;
    logic           r_zero, w_zero_nxt;

    cmd_e           w_cmd;
    logic [EW:0]    w_sum9;
    logic [KW-1:0]  w_align_k;
    logic [KW-1:0]  w_norm_k;
    logic [KW-1:0]  w_rsh_amt;
    logic [KW-1:0]  w_lz;
    logic [MW-1:0]  w_rsh;
    logic [MW-1:0]  w_lsh;
    logic [MW-1:0]  w_drop_mask;
    logic [MW-1:0]  w_rsh_sticky;

    assign w_cmd  = cmd_e'(in_cmd);
    // The carry out of this 9-bit sum is the exponent overflow indication.
    assign w_sum9 = {1'b0, in_exp} + {1'b0, in_shamt};

    // ------------------------------------------------------------------
    // Step-size selection
    // ------------------------------------------------------------------
    assign w_align_k = (r_rem < STEP_E) ? r_rem[KW-1:0] : STEP_K;

    // NORM step: min(leading zeros, STEP, exp-1). exp >= 2 whenever the
    // result is used, so exp-1 never wraps in that case.
    always_comb begin
        w_norm_k = w_lz;
        if (STEP_K < w_norm_k) begin
            w_norm_k = STEP_K;
        end
        if ({{(EW-KW){1'b0}}, w_norm_k} > (r_exp - 8'd1)) begin
            w_norm_k = KW'(r_exp - 8'd1);
        end
    end

    // In NORM the right shifter only serves the carry case, a 1-bit shift.
    assign w_rsh_amt = (r_state == S_NORM) ? KW'(1) : w_align_k;

    lzc28 u_lzc (
        .mantis (r_mantis[HIDDEN_BIT:0]),
        .count  (w_lz)
    );

    fp_step_shifter #(.W(MW), .AW(KW), .LEFT(1'b0)) u_rshift (
        .data   (r_mantis),
        .amt    (w_rsh_amt),
        .result (w_rsh)
    );

    fp_step_shifter #(.W(MW), .AW(KW), .LEFT(1'b1)) u_lshift (
        .data   (r_mantis),
        .amt    (w_norm_k),
        .result (w_lsh)
    );

    // Bits falling off the bottom of the right shift fold into bit 0.
    assign w_drop_mask  = ~({MW{1'b1}} << w_rsh_amt);
    assign w_rsh_sticky = {w_rsh[MW-1:1], w_rsh[0] | (|(r_mantis & w_drop_mask))};

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_exp_nxt    = r_exp;
        w_mantis_nxt = r_mantis;
        w_rem_nxt    = r_rem;
        w_ovf_nxt    = r_ovf;
        w_unf_nxt    = r_unf;
        w_zero_nxt   = r_zero;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_exp_nxt    = in_exp;
                    w_mantis_nxt = in_mantis;
                    w_rem_nxt    = in_shamt;
                    w_ovf_nxt    = 1'b0;
                    w_unf_nxt    = 1'b0;
                    w_zero_nxt   = 1'b0;
                    if (w_cmd == CMD_NORM) begin
                        w_state_nxt = S_NORM;
                    end else begin
                        // Exponent adjustment is applied once, up front.
                        if (w_sum9[EW]) begin
                            w_exp_nxt = EXP_MAX;
                            w_ovf_nxt = 1'b1;
                        end else begin
                            w_exp_nxt = w_sum9[EW-1:0];
                        end
                        if (in_shamt == '0) begin
                            w_state_nxt = S_DONE;
                        end else if (in_shamt >= EW'(MW)) begin
                            // Everything shifts out: only the sticky survives.
                            w_mantis_nxt = {{(MW-1){1'b0}}, |in_mantis};
                            w_state_nxt  = S_DONE;
                        end else begin
                            w_state_nxt = S_ALIGN;
                        end
                    end
                end
            end

            S_ALIGN: begin
                w_mantis_nxt = w_rsh_sticky;
                w_rem_nxt    = r_rem - {{(EW-KW){1'b0}}, w_align_k};
                if (r_rem == {{(EW-KW){1'b0}}, w_align_k}) begin
                    w_state_nxt = S_DONE;
                end
            end

            S_NORM: begin
                if (r_mantis == '0) begin
                    w_exp_nxt   = '0;
                    w_zero_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_mantis[CARRY_BIT]) begin
                    w_mantis_nxt = w_rsh_sticky;
                    if (r_exp >= EXP_MAX - 8'd1) begin
                        w_exp_nxt = EXP_MAX;
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_exp_nxt = r_exp + 8'd1;
                    end
                    w_state_nxt = S_DONE;
                end else if (r_mantis[HIDDEN_BIT]) begin
                    w_state_nxt = S_DONE;
                end else if (r_exp <= 8'd1) begin
                    w_exp_nxt   = '0;
                    w_unf_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_mantis_nxt = w_lsh;
                    w_exp_nxt    = r_exp - {{(EW-KW){1'b0}}, w_norm_k};
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_exp    <= '0;
            r_mantis <= '0;
            r_rem    <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_exp    <= w_exp_nxt;
            r_mantis <= w_mantis_nxt;
            r_rem    <= w_rem_nxt;
            r_ovf    <= w_ovf_nxt;
            r_unf    <= w_unf_nxt;
            r_zero   <= w_zero_nxt;
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign out_exp    = r_exp;
    assign out_mantis = r_mantis;
    assign out_ovf    = r_ovf;
    assign out_unf    = r_unf;
    assign out_zero   = r_zero;

endmodule : fp_shift_sequencer
`default_nettype wire

// File: tb/tb_fp_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_shift_sequencer
// Description : Self-checking bench for fp_shift_sequencer. Directed cases
//               with hand-derived results, randomized commands against a
//               behavioural model, handshake hold and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_shift_sequencer;

    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_cmd;
    logic [7:0]  in_exp;
    logic [27:0] in_mantis;
    logic [7:0]  in_shamt;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_exp;
    logic [27:0] out_mantis;
    logic        out_ovf;
    logic        out_unf;
    logic        out_zero;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fp_shift_sequencer #(.STEP(STEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cmd     (in_cmd),
        .in_exp     (in_exp),
        .in_mantis  (in_mantis),
        .in_shamt   (in_shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_exp    (out_exp),
        .out_mantis (out_mantis),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf),
        .out_zero   (out_zero),
        .busy       (busy)
    );

    // Directed table: cmd, exp, mantissa, shamt -> exp, mantissa, {ovf,unf,zero}, latency
    localparam int ND = 10;
    bit          d_cmd [ND] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    logic [7:0]  d_e   [ND] = '{10, 5, 50, 250, 7, 20, 254, 77, 3, 254};
    logic [27:0] d_m   [ND] = '{28'h4000000, 28'h4000003, 28'h0000005, 28'h0001000, 28'h1234567,
                                28'h0080000, 28'h8000000, 28'h0000000, 28'h0000100, 28'h8000001};
    logic [7:0]  d_s   [ND] = '{9, 2, 40, 10, 0, 0, 0, 0, 0, 0};
    logic [7:0]  d_xe  [ND] = '{19, 7, 90, 255, 7, 13, 255, 0, 0, 255};
    logic [27:0] d_xm  [ND] = '{28'h0020000, 28'h1000001, 28'h0000001, 28'h0000004, 28'h1234567,
                                28'h4000000, 28'h4000000, 28'h0000000, 28'h0000400, 28'h4000001};
    logic [2:0]  d_xf  [ND] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000,
                                3'b000, 3'b100, 3'b001, 3'b010, 3'b100};
    int          d_xl  [ND] = '{4, 2, 1, 4, 1, 4, 2, 2, 3, 2};

    // Behavioural reference: whole-operation arithmetic, no per-cycle stepping.
    function automatic void model(input bit cmd, input int e, input logic [27:0] m, input int s,
                                  output int xe, output logic [27:0] xm, output logic [2:0] xf,
                                  output int xl);
        logic [63:0] w;
        int pos, need, sh;
        w  = {36'd0, m};
        xf = 3'b000;
        xe = e;
        xm = m;
        if (!cmd) begin
            if (e + s > 255) begin
                xe = 255;
                xf[2] = 1'b1;
            end else begin
                xe = e + s;
            end
            if (s >= 28) xm = {27'd0, |m};
            else         xm = 28'(w >> s) | {27'd0, ((w & ((64'd1 << s) - 64'd1)) != 64'd0)};
            xl = (s == 0 || s >= 28) ? 1 : 1 + (s + STEP - 1) / STEP;
        end else begin
            xl = 2;
            if (m == 28'd0) begin
                xe = 0;
                xf[0] = 1'b1;
            end else if (m[27]) begin
                xm = (m >> 1) | {27'd0, m[0]};
                if (e + 1 >= 255) begin
                    xe = 255;
                    xf[2] = 1'b1;
                end else begin
                    xe = e + 1;
                end
            end else if (!m[26]) begin
                pos = 0;
                for (int i = 0; i < 27; i++) if (m[i]) pos = i;
                need = 26 - pos;
                if (e > need) begin
                    sh = need;
                    xe = e - need;
                end else begin
                    sh = (e > 0) ? e - 1 : 0;
                    xe = 0;
                    xf[1] = 1'b1;
                end
                xm = 28'(w << sh);
                xl = 1 + (sh + STEP - 1) / STEP + 1;
            end
        end
    endfunction

    // Issues one command from IDLE and waits (bounded) for out_valid.
    task automatic run_cmd(input bit cmd, input logic [7:0] e, input logic [27:0] m,
                           input logic [7:0] s, output logic [7:0] ge, output logic [27:0] gm,
                           output logic [2:0] gf, output int lat);
        in_valid  = 1'b1;
        in_cmd    = cmd;
        in_exp    = e;
        in_mantis = m;
        in_shamt  = s;
        @(negedge clk);
        in_valid  = 1'b0;
        in_cmd    = 1'($urandom);
        in_exp    = 8'($urandom);
        in_mantis = 28'($urandom);
        in_shamt  = 8'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        ge = out_exp;
        gm = out_mantis;
        gf = {out_ovf, out_unf, out_zero};
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL reset_hs: got ready/valid/busy=%b expected 100", {in_ready, out_valid, busy});
        else n_pass++;
        n_checks++;
        if ({out_exp, out_mantis} !== 36'd0) $display("FAIL reset_data: got exp=%h mantis=%h expected 0/0", out_exp, out_mantis);
        else n_pass++;
        n_checks++;
        if ({out_ovf, out_unf, out_zero} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {out_ovf, out_unf, out_zero});
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [7:0]  ge;
        logic [27:0] gm;
        logic [2:0]  gf;
        int          lat;
        for (int i = 0; i < ND; i++) begin
            run_cmd(d_cmd[i], d_e[i], d_m[i], d_s[i], ge, gm, gf, lat);
            n_checks++;
            if (ge !== d_xe[i]) $display("FAIL dir%0d_exp: got %0d expected %0d", i, ge, d_xe[i]);
            else n_pass++;
            n_checks++;
            if (gm !== d_xm[i]) $display("FAIL dir%0d_mantis: got %h expected %h", i, gm, d_xm[i]);
            else n_pass++;
            n_checks++;
            if (gf !== d_xf[i]) $display("FAIL dir%0d_flags: got %b expected %b", i, gf, d_xf[i]);
            else n_pass++;
            n_checks++;
            if (lat != d_xl[i]) $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, d_xl[i]);
            else n_pass++;
            release_result();
        end
    endtask

    task automatic test_random();
        logic [7:0]  ge, e, s;
        logic [27:0] gm, m, xm;
        logic [2:0]  gf, xf;
        int          lat, xe, xl;
        bit          cmd;
        for (int i = 0; i < 60; i++) begin
            cmd = 1'($urandom);
            m   = 28'($urandom) >> $urandom_range(0, 28);
            if ($urandom_range(0, 7) == 0) m = m | 28'h8000000;
            case ($urandom_range(0, 2))
                0:       e = 8'($urandom_range(0, 8));
                1:       e = 8'($urandom_range(248, 255));
                default: e = 8'($urandom);
            endcase
            s = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 30));
            model(cmd, int'(e), m, int'(s), xe, xm, xf, xl);
            run_cmd(cmd, e, m, s, ge, gm, gf, lat);
            n_checks++;
            if (int'(ge) != xe) $display("FAIL rnd%0d_exp: cmd=%0d e=%0d m=%h s=%0d got %0d expected %0d", i, cmd, e, m, s, ge, xe);
            else n_pass++;
            n_checks++;
            if (gm !== xm) $display("FAIL rnd%0d_mantis: cmd=%0d e=%0d m=%h s=%0d got %h expected %h", i, cmd, e, m, s, gm, xm);
            else n_pass++;
            n_checks++;
            if (gf !== xf) $display("FAIL rnd%0d_flags: cmd=%0d e=%0d m=%h s=%0d got %b expected %b", i, cmd, e, m, s, gf, xf);
            else n_pass++;
            n_checks++;
            if (lat != xl) $display("FAIL rnd%0d_latency: cmd=%0d e=%0d m=%h s=%0d got %0d expected %0d", i, cmd, e, m, s, lat, xl);
            else n_pass++;
            release_result();
        end
    endtask

    task automatic test_hold();
        logic [7:0]  ge;
        logic [27:0] gm;
        logic [2:0]  gf;
        int          lat;
        run_cmd(1'b0, 8'd10, 28'h4000000, 8'd9, ge, gm, gf, lat);
        for (int i = 0; i < 5; i++) begin
            // New commands while the result is held must be ignored.
            in_valid  = 1'b1;
            in_cmd    = 1'b1;
            in_exp    = 8'($urandom);
            in_mantis = 28'($urandom);
            @(negedge clk);
            n_checks++;
            if ({out_valid, in_ready, busy} !== 3'b101) $display("FAIL hold%0d_hs: got valid/ready/busy=%b expected 101", i, {out_valid, in_ready, busy});
            else n_pass++;
            n_checks++;
            if ({out_exp, out_mantis} !== {8'd19, 28'h0020000}) $display("FAIL hold%0d_data: got exp=%0d mantis=%h expected 19/0020000", i, out_exp, out_mantis);
            else n_pass++;
        end
        // Release with in_valid still high: must not be taken in the same cycle.
        in_valid  = 1'b1;
        in_exp    = 8'd20;
        in_mantis = 28'h0080000;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) $display("FAIL release_hs: got valid/ready/busy=%b expected 010", {out_valid, in_ready, busy});
        else n_pass++;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL release_idle: got busy=%b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        in_valid  = 1'b1;
        in_cmd    = 1'b0;
        in_exp    = 8'd40;
        in_mantis = 28'h5A5A5A5;
        in_shamt  = 8'd27;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b expected 1", busy);
        else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL midrst_hs: got ready/valid/busy=%b expected 100", {in_ready, out_valid, busy});
        else n_pass++;
        n_checks++;
        if ({out_exp, out_mantis} !== 36'd0) $display("FAIL midrst_data: got exp=%h mantis=%h expected 0/0", out_exp, out_mantis);
        else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL midrst_no_result: got out_valid seen=%b expected 0", seen);
        else n_pass++;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_cmd    = 1'b0;
        in_exp    = '0;
        in_mantis = '0;
        in_shamt  = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_directed();
        test_random();
        test_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fp_shift_sequencer
`default_nettype wire
